booth_mul_seq: RTL and testbench

- Multi-cycle sequencer for the signed radix-2 Booth multiply used by the CPU's MULT instruction.
- Accepts operands on a start/busy/done handshake and performs one Booth add/subtract-and-shift step per clock.
- On completion, loads the 64-bit product into architectural HI/LO registers that MFHI/MFLO read directly.
- Replaces the single-cycle unrolled multiplier on the critical path with a WIDTH-cycle iterative datapath.

---
 rtl/booth_mul_seq_if.sv | 24 ++
 rtl/booth_mul_seq.sv | 157 +++++++++++++++
 tb/tb_booth_mul_seq.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/booth_mul_seq_if.sv
// Handshake and result bundle for the sequential Booth multiplier.
// The requester uses the master view; the multiplier uses the slave view.
interface booth_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] x_in;
    logic [WIDTH-1:0] y_in;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, x_in, y_in,
        input  ready, busy, done, hi, lo
    );

    modport slave (
        input  start, x_in, y_in,
        output ready, busy, done, hi, lo
    );
endinterface

// File: rtl/booth_mul_seq.sv
// Sequential signed radix-2 Booth multiplier feeding the HI/LO registers.
// One add/subtract-and-shift step per clock; HI/LO change only on completion.
// Optional macro BOOTH_MUL_EARLY_TERM_EN: when every multiplier bit still to
// be scanned equals e1, the remaining pure shifts collapse into one cycle.
module booth_mul_seq #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           reset_n,
    booth_mul_seq_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] acc_r;
    logic [WIDTH-1:0] q_r;
    logic             e1_r;
    logic [WIDTH-1:0] ycap_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             ready_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] acc_nxt_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic             e1_nxt_s;
    logic             last_s;

`ifdef BOOTH_MUL_EARLY_TERM_EN
    logic                   early_s;
    logic [CNT_W:0]         shamt_s;
    logic signed [2*WIDTH:0] wide_s;
`endif

    // One extra bit keeps the true sign when acc +/- ycap overflows WIDTH bits.
    function automatic logic [WIDTH:0] booth_addsub(
        input logic [1:0]       pair,
        input logic [WIDTH-1:0] acc,
        input logic [WIDTH-1:0] y
    );
        logic [WIDTH:0] a_ext;
        logic [WIDTH:0] y_ext;
        logic [WIDTH:0] r;
        a_ext = {acc[WIDTH-1], acc};
        y_ext = {y[WIDTH-1], y};
        case (pair)
            2'b10:   r = a_ext + ~y_ext + {{WIDTH{1'b0}}, 1'b1};
            2'b01:   r = a_ext + y_ext;
            default: r = a_ext;
        endcase
        return r;
    endfunction

    // Next {acc,q,e1}: Booth add/sub on {q[0],e1} then 1-bit arithmetic shift.
    always_comb begin
        sum_s     = booth_addsub({q_r[0], e1_r}, acc_r, ycap_r);
        acc_nxt_s = sum_s[WIDTH:1];
        q_nxt_s   = {sum_s[0], q_r[WIDTH-1:1]};
        e1_nxt_s  = q_r[0];
        last_s    = (cnt_r == CNT_W'(WIDTH - 1));
`ifdef BOOTH_MUL_EARLY_TERM_EN
        // Unscanned multiplier bits sit in q[WIDTH-1-cnt:0].
        early_s = (((q_r ^ {WIDTH{e1_r}}) & ({WIDTH{1'b1}} >> cnt_r)) == {WIDTH{1'b0}});
        shamt_s = (CNT_W + 1)'(WIDTH) - {1'b0, cnt_r};
        wide_s  = $signed({acc_r, q_r, e1_r}) >>> shamt_s;
        if (early_s) begin
            acc_nxt_s = wide_s[2*WIDTH:WIDTH+1];
            q_nxt_s   = wide_s[WIDTH:1];
            e1_nxt_s  = wide_s[0];
            last_s    = 1'b1;
        end else begin
            acc_nxt_s = sum_s[WIDTH:1];
            q_nxt_s   = {sum_s[0], q_r[WIDTH-1:1]};
            e1_nxt_s  = q_r[0];
            last_s    = (cnt_r == CNT_W'(WIDTH - 1));
        end
`endif
    end

    // Control FSM, iterative datapath and registered handshake/result outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            acc_r   <= {WIDTH{1'b0}};
            q_r     <= {WIDTH{1'b0}};
            e1_r    <= 1'b0;
            ycap_r  <= {WIDTH{1'b0}};
            cnt_r   <= {CNT_W{1'b0}};
            hi_r    <= {WIDTH{1'b0}};
            lo_r    <= {WIDTH{1'b0}};
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (!ready_r) begin
                        // done-pulse cycle: start is not accepted until ready returns
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b0;
                    end else if (bus.start) begin
                        acc_r   <= {WIDTH{1'b0}};
                        q_r     <= bus.x_in;
                        e1_r    <= 1'b0;
                        ycap_r  <= bus.y_in;
                        cnt_r   <= {CNT_W{1'b0}};
                        ready_r <= 1'b0;
                        busy_r  <= 1'b1;
                        state_r <= ST_RUN;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc_r <= acc_nxt_s;
                    q_r   <= q_nxt_s;
                    e1_r  <= e1_nxt_s;
                    cnt_r <= cnt_r + CNT_W'(1);
                    if (last_s) begin
                        state_r <= ST_DONE;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_DONE: begin
                    hi_r    <= acc_r;
                    lo_r    <= q_r;
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r <= ST_IDLE;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ready = ready_r;
    assign bus.busy  = busy_r;
    assign bus.done  = done_r;
    assign bus.hi    = hi_r;
    assign bus.lo    = lo_r;

endmodule

// File: tb/tb_booth_mul_seq.sv
// Directed self-checking bench for booth_mul_seq (default build, WIDTH=32).
module tb_booth_mul_seq;

    logic clk;
    logic reset_n;
    int   n_checks;
    int   n_fail;

    booth_mul_seq_if #(.WIDTH(32)) bus ();

    booth_mul_seq #(.WIDTH(32), .CNT_W(6)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Global time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one multiply; return cycles from start edge to visible done and
    // whether busy=1/ready=0/done=0 held on every cycle before done.
    task automatic do_mul(input logic [31:0] x, input logic [31:0] y,
                          output int lat, output logic hs_ok);
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = x;
        bus.y_in  = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.x_in  = ~x;
        bus.y_in  = ~y;
        lat   = 0;
        hs_ok = 1'b1;
        while (bus.done !== 1'b1 && lat < 100) begin
            if (bus.busy !== 1'b1 || bus.ready !== 1'b0) hs_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    // Checks on the done cycle and the cycle after it.
    task automatic post_done(input string tag);
        chk({tag, "_ready_at_done"}, {63'd0, bus.ready}, 64'd0);
        chk({tag, "_busy_at_done"}, {63'd0, bus.busy}, 64'd1);
        @(posedge clk);
        #1;
        chk({tag, "_done_clear"}, {63'd0, bus.done}, 64'd0);
        chk({tag, "_ready_back"}, {63'd0, bus.ready}, 64'd1);
    endtask

    task automatic mul_case(input string tag, input logic [31:0] x, input logic [31:0] y,
                            input logic [63:0] prod);
        int   lat;
        logic hs_ok;
        do_mul(x, y, lat, hs_ok);
        chk({tag, "_latency"}, 64'(lat), 64'd33);
        chk({tag, "_handshake"}, {63'd0, hs_ok}, 64'd1);
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, prod[63:32]});
        chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, prod[31:0]});
        post_done(tag);
    endtask

    initial begin
        int   n_done;
        int   done_at;
        logic saw_done;

        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.x_in  = 32'd0;
        bus.y_in  = 32'd0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", {63'd0, bus.ready}, 64'd1);
        chk("rst_busy",  {63'd0, bus.busy},  64'd0);
        chk("rst_done",  {63'd0, bus.done},  64'd0);
        chk("rst_hi",    {32'd0, bus.hi},    64'd0);
        chk("rst_lo",    {32'd0, bus.lo},    64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Directed products (hand-computed)
        mul_case("m3x5",    32'd3,          32'd5,          64'h00000000_0000000F);
        mul_case("mneg7x6", 32'hFFFFFFF9,   32'd6,          64'hFFFFFFFF_FFFFFFD6);
        mul_case("mminmin", 32'h80000000,   32'h80000000,   64'h40000000_00000000);
        mul_case("mmaxmin", 32'h7FFFFFFF,   32'h80000000,   64'hC0000000_80000000);
        mul_case("mm1xm1",  32'hFFFFFFFF,   32'hFFFFFFFF,   64'h00000000_00000001);
        mul_case("mbig",    32'h12345678,   32'h00000010,   64'h00000001_23456780);

        // start during RUN (cycle 5) and during the done cycle is ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 32'd100;
        bus.y_in  = 32'd200;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        n_done  = 0;
        done_at = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 5) begin
                bus.start = 1'b1;
                bus.x_in  = 32'h0000FFFF;
                bus.y_in  = 32'h0000FFFF;
            end else if (bus.done === 1'b1) begin
                bus.start = 1'b1;
                bus.x_in  = 32'd7;
                bus.y_in  = 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                n_done++;
                done_at = c;
            end
        end
        chk("ign_done_count", 64'(n_done), 64'd1);
        chk("ign_done_cycle", 64'(done_at), 64'd33);
        chk("ign_hi", {32'd0, bus.hi}, 64'd0);
        chk("ign_lo", {32'd0, bus.lo}, 64'h0000_4E20);
        chk("ign_idle_ready", {63'd0, bus.ready}, 64'd1);
        mul_case("after_ign", 32'hFFFFFFFD, 32'd7, 64'hFFFFFFFF_FFFFFFEB);

        // Reset asserted mid-RUN abandons the operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.x_in  = 32'h11111111;
        bus.y_in  = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("mid_hi_hold", {32'd0, bus.hi}, 64'hFFFFFFFF);
        chk("mid_lo_hold", {32'd0, bus.lo}, 64'hFFFFFFEB);
        chk("mid_busy", {63'd0, bus.busy}, 64'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_hi",    {32'd0, bus.hi},    64'd0);
        chk("abort_lo",    {32'd0, bus.lo},    64'd0);
        chk("abort_ready", {63'd0, bus.ready}, 64'd1);
        chk("abort_busy",  {63'd0, bus.busy},  64'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (bus.done !== 1'b0) saw_done = 1'b1;
        end
        chk("abort_no_done", {63'd0, saw_done}, 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        mul_case("after_rst", 32'd9, 32'd9, 64'h00000000_00000051);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
